// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - three-state job sequencer that holds mode at start for a requested number of cycles
//
// Purpose:
//   Accepts a job request of length N while idle. It holds mode=start for N
//   cycles, then spends one DONE cycle that strobes done_pulse and counts the
//   job. Then it returns to IDLE. A request with N=0 skips the start phase
//   entirely. Every output is a register loaded from next-state values, so no
//   output depends combinationally on an input.
//
// Optional feature:
//   MODE_SEQ_ABORT_EN - adds the abort input and the aborted output. When abort
//   is sampled high in RUN, the next cycle is forced to DONE and aborted=1 for
//   that cycle.
//
// Ports:
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous active-high reset
//   req_valid   in   1      job request present
//   req_len     in   LEN_W  cycles to hold mode at start
//   abort       in   1      (MODE_SEQ_ABORT_EN only) end the running job early
//   req_ready   out  1      high only in IDLE
//   mode        out  mode_t start while a job runs, done otherwise
//   busy        out  1      high in RUN and DONE
//   done_pulse  out  1      one-cycle completion strobe (the DONE cycle)
//   remaining   out  LEN_W  cycles left in the current RUN, 0 otherwise
//   aborted     out  1      (MODE_SEQ_ABORT_EN only) DONE reached via abort
//   job_cnt     out  CNT_W  completed-job counter, wraps

package P1;
    typedef enum logic {
        start = 1'b0,
        done  = 1'b1
    } mode_t;
endpackage

module mode_sequencer
    import P1::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
`ifdef MODE_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             req_ready,
    output mode_t            mode,
    output logic             busy,
    output logic             done_pulse,
    output logic [LEN_W-1:0] remaining,
    output logic [CNT_W-1:0] job_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_job_cnt;
    mode_t            r_mode;
    logic             r_busy;
    logic             r_done_pulse;
    logic             r_req_ready;

    state_t           w_state_nxt;
    logic [LEN_W-1:0] w_remaining_nxt;
    logic [CNT_W-1:0] w_job_cnt_nxt;
    mode_t            w_mode_nxt;
    logic             w_busy_nxt;
    logic             w_done_pulse_nxt;
    logic             w_req_ready_nxt;

`ifdef MODE_SEQ_ABORT_EN
    logic             r_aborted;
    logic             w_aborted_nxt;
`endif

    // Next-state and next-output logic.
    // Outputs are derived from the state being entered, not the current one.
    // That way the registered outputs line up with the state they describe.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_job_cnt_nxt   = r_job_cnt;
`ifdef MODE_SEQ_ABORT_EN
        w_aborted_nxt   = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_len == '0) begin
                        // Zero-length job: no start cycle at all.
                        w_state_nxt     = S_DONE;
                        w_remaining_nxt = '0;
                    end else begin
                        w_state_nxt     = S_RUN;
                        w_remaining_nxt = req_len;
                    end
                end
            end

            S_RUN: begin
`ifdef MODE_SEQ_ABORT_EN
                if (abort) begin
                    w_state_nxt     = S_DONE;
                    w_remaining_nxt = '0;
                    w_aborted_nxt   = 1'b1;
                end else
`endif
                if (r_remaining == LEN_W'(1)) begin
                    // Last start cycle: leave RUN without decrementing below 1.
                    // This keeps N = 2^LEN_W-1 safe from wrap-around.
                    w_state_nxt     = S_DONE;
                    w_remaining_nxt = '0;
                end else begin
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                end
            end

            S_DONE: begin
                w_state_nxt     = S_IDLE;
                w_remaining_nxt = '0;
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_remaining_nxt = '0;
            end
        endcase

        // The job is counted on entry to DONE.
        // This makes the new count visible together with done_pulse.
        if (w_state_nxt == S_DONE) begin
            w_job_cnt_nxt = r_job_cnt + CNT_W'(1);
        end

        w_mode_nxt       = (w_state_nxt == S_RUN) ? start : done;
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_done_pulse_nxt = (w_state_nxt == S_DONE);
        w_req_ready_nxt  = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_job_cnt    <= '0;
            r_mode       <= done;
            r_busy       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_req_ready  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_job_cnt    <= w_job_cnt_nxt;
            r_mode       <= w_mode_nxt;
            r_busy       <= w_busy_nxt;
            r_done_pulse <= w_done_pulse_nxt;
            r_req_ready  <= w_req_ready_nxt;
        end
    end

`ifdef MODE_SEQ_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_aborted_nxt;
        end
    end

    assign aborted = r_aborted;
`endif

    assign req_ready  = r_req_ready;
    assign mode       = r_mode;
    assign busy       = r_busy;
    assign done_pulse = r_done_pulse;
    assign remaining  = r_remaining;
    assign job_cnt    = r_job_cnt;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - self-checking bench for mode_sequencer (reference model plus directed vectors)

module tb_mode_sequencer;

    localparam int LEN_W = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [LEN_W-1:0] req_len = '0;
    logic             abort_s = 1'b0;

    logic             req_ready;
    P1::mode_t        mode;
    logic             busy;
    logic             done_pulse;
    logic [LEN_W-1:0] remaining;
    logic [CNT_W-1:0] job_cnt;
    logic             aborted_s;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mode_sequencer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_len    (req_len),
`ifdef MODE_SEQ_ABORT_EN
        .abort      (abort_s),
        .aborted    (aborted_s),
`endif
        .req_ready  (req_ready),
        .mode       (mode),
        .busy       (busy),
        .done_pulse (done_pulse),
        .remaining  (remaining),
        .job_cnt    (job_cnt)
    );

`ifndef MODE_SEQ_ABORT_EN
    assign aborted_s = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model.
    // A job is a list of per-cycle records: N start records, then one done
    // record. An empty list means the sequencer is idle.
    typedef struct packed {
        logic             st;
        logic [LEN_W-1:0] rem;
        logic             ab;
    } rec_t;

    rec_t             q[$];
    logic [CNT_W-1:0] mcnt;

    always @(posedge clk or posedge rst) begin : model
        rec_t cur;
        if (rst) begin
            q.delete();
            mcnt = '0;
        end else if (q.size() == 0) begin
            if (req_valid) begin
                for (int i = int'(req_len); i >= 1; i--) q.push_back('{1'b1, LEN_W'(i), 1'b0});
                q.push_back('{1'b0, LEN_W'(0), 1'b0});
            end
        end else begin
            cur = q.pop_front();
            if (!cur.st) mcnt = mcnt + 1'b1;
            else if (abort_s) begin
                q.delete();
                q.push_back('{1'b0, LEN_W'(0), 1'b1});
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic             e_idle, e_start, e_dp, e_ab;
        logic [LEN_W-1:0] e_rem;
        logic [CNT_W-1:0] e_cnt;
        if (!rst) begin
            if (q.size() == 0) begin
                e_idle = 1'b1; e_start = 1'b0; e_dp = 1'b0; e_ab = 1'b0; e_rem = '0; e_cnt = mcnt;
            end else begin
                e_idle  = 1'b0;
                e_start = q[0].st;
                e_dp    = !q[0].st;
                e_ab    = q[0].ab;
                e_rem   = q[0].rem;
                e_cnt   = q[0].st ? mcnt : mcnt + 1'b1;
            end
            chk("m_mode_is_start", {31'd0, mode == P1::start}, {31'd0, e_start});
            chk("m_req_ready", {31'd0, req_ready}, {31'd0, e_idle});
            chk("m_busy", {31'd0, busy}, {31'd0, !e_idle});
            chk("m_done_pulse", {31'd0, done_pulse}, {31'd0, e_dp});
            chk("m_remaining", 32'(remaining), 32'(e_rem));
            chk("m_job_cnt", 32'(job_cnt), 32'(e_cnt));
            chk("m_aborted", {31'd0, aborted_s}, {31'd0, e_ab});
        end
    end

    // Watches one job from its accept edge.
    // Reports how many start cycles were seen, the cycle offset of done_pulse,
    // and the cycle offset at which req_ready came back.
    task automatic observe(input int budget, output int starts, output int dp_at, output int ready_at);
        starts = 0; dp_at = -1; ready_at = -1;
        @(posedge clk);
        for (int j = 1; j <= budget; j++) begin
            @(negedge clk);
            if (j == 1) req_valid = 1'b0;
            if (mode == P1::start) starts++;
            if (done_pulse && dp_at < 0) dp_at = j;
            if (dp_at > 0 && req_ready) begin
                ready_at = j;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int s, d, r, dps, first_dp, second_dp;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_mode", 32'(mode), 32'(P1::done));
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_pulse", {31'd0, done_pulse}, 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        chk("rst_job_cnt", 32'(job_cnt), 32'd0);

        // N=3, accepted on the first edge after reset release.
        rst = 1'b0; req_valid = 1'b1; req_len = 8'd3;
        observe(20, s, d, r);
        chk("n3_starts", s, 3);
        chk("n3_done_at", d, 4);
        chk("n3_ready_at", r, 5);
        chk("n3_job_cnt", 32'(job_cnt), 32'd1);

        // N=0.
        req_valid = 1'b1; req_len = 8'd0;
        observe(20, s, d, r);
        chk("n0_starts", s, 0);
        chk("n0_done_at", d, 1);
        chk("n0_ready_at", r, 2);
        chk("n0_job_cnt", 32'(job_cnt), 32'd2);

        // req_valid held through a len=5 job, then len=2 taken when ready returns.
        req_valid = 1'b1; req_len = 8'd5;
        s = 0; dps = 0; first_dp = -1; second_dp = -1;
        @(posedge clk);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (mode == P1::start) s++;
            if (done_pulse) begin
                dps++;
                if (first_dp < 0) first_dp = j; else second_dp = j;
            end
            if (j == 1) req_len = 8'd2;
            if (j == 8) req_valid = 1'b0;
        end
        chk("hold_starts", s, 7);
        chk("hold_dp_count", dps, 2);
        chk("hold_first_dp", first_dp, 6);
        chk("hold_second_dp", second_dp, 10);
        chk("hold_job_cnt", 32'(job_cnt), 32'd4);

        // Asynchronous reset during the 2nd cycle of a len=4 job.
        req_valid = 1'b1; req_len = 8'd4;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_mode", 32'(mode), 32'(P1::done));
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_remaining", 32'(remaining), 32'd0);
        chk("arst_job_cnt", 32'(job_cnt), 32'd0);
        @(negedge clk); rst = 1'b0;
        dps = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (done_pulse) dps++;
        end
        chk("arst_no_done", dps, 0);
        chk("arst_job_cnt_after", 32'(job_cnt), 32'd0);

        // Counter wrap plus the maximum length.
        @(posedge clk); #2;
        force dut.r_job_cnt = 16'hFFFF;
        mcnt = 16'hFFFF;
        @(posedge clk); #2;
        release dut.r_job_cnt;
        @(negedge clk);
        chk("force_job_cnt", 32'(job_cnt), 32'h0000FFFF);
        req_valid = 1'b1; req_len = 8'd255;
        observe(300, s, d, r);
        chk("n255_starts", s, 255);
        chk("n255_done_at", d, 256);
        chk("n255_ready_at", r, 257);
        chk("wrap_job_cnt", 32'(job_cnt), 32'd0);

`ifdef MODE_SEQ_ABORT_EN
        // Abort sampled in the 3rd RUN cycle of a len=10 job.
        req_valid = 1'b1; req_len = 8'd10;
        s = 0;
        @(posedge clk);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) req_valid = 1'b0;
            if (mode == P1::start) s++;
            if (j == 3) abort_s = 1'b1;
            if (j == 4) begin
                chk("ab_done_pulse", {31'd0, done_pulse}, 32'd1);
                chk("ab_aborted", {31'd0, aborted_s}, 32'd1);
                chk("ab_remaining", 32'(remaining), 32'd0);
            end
            if (j == 5) begin
                chk("ab_ready", {31'd0, req_ready}, 32'd1);
                chk("ab_aborted_clear", {31'd0, aborted_s}, 32'd0);
            end
        end
        abort_s = 1'b0;
        chk("ab_starts", s, 3);
        chk("ab_job_cnt", 32'(job_cnt), 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 The module SHALL import package P1 in its module header, so that type P1 mode_t {start, done} is visible to the port list.
REQ-002 Parameter LEN_W, default 8: width of the requested run length.
REQ-003 Parameter CNT_W, default 16: width of the completed-job counter.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  a job request is present.
REQ-007 req_len  input  LEN_W  number of cycles mode is held at start.
REQ-008 req_ready  output  1  sequencer accepts a request this cycle.
REQ-009 mode  output  mode_t  start while a job runs, done otherwise; drives a mode_t consumer.
REQ-010 busy  output  1  high in RUN and DONE states.
REQ-011 done_pulse  output  1  one-cycle job-completion strobe.
REQ-012 remaining  output  LEN_W  cycles left in the current RUN.
REQ-013 job_cnt  output  CNT_W  count of completed jobs.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 All outputs SHALL be registered; none SHALL be combinationally dependent on inputs.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-017 req_valid SHALL be ignored outside IDLE, and such requests SHALL be neither queued nor counted.
REQ-018 On accept with req_len=N>0, the FSM SHALL go to RUN and load remaining=N.
REQ-019 In RUN, remaining SHALL decrement by 1 per cycle.
REQ-020 When remaining=1, the FSM SHALL go to DONE at the next edge.
REQ-021 For N>0, mode SHALL equal start for exactly N cycles: cycles k+1..k+N after the accept edge k.
REQ-022 On accept with req_len=0, the FSM SHALL go directly to DONE, with mode staying done and no start cycle.
REQ-023 DONE SHALL last exactly one cycle, with done_pulse=1, mode=done and remaining=0; the next state SHALL be IDLE.
REQ-024 Latency: for N>0, done_pulse SHALL occur at cycle k+N+1 and req_ready=1 again at k+N+2.
REQ-025 Latency: for N=0, done_pulse SHALL occur at k+1 and req_ready=1 again at k+2.
REQ-026 job_cnt SHALL increment by 1 on each DONE cycle, wrapping from 2^CNT_W-1 to 0.
REQ-027 The maximum N = 2^LEN_W-1 SHALL be supported without overflow.

Reset
REQ-028 While rst=1, asynchronously, state SHALL be IDLE, mode=done, req_ready=1, busy=0, done_pulse=0, remaining=0 and job_cnt=0.
REQ-029 Reset asserted mid-RUN SHALL abandon the job, with no done_pulse and no job_cnt increment.
REQ-030 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro MODE_SEQ_ABORT_EN SHALL control the abort feature.
REQ-032 With MODE_SEQ_ABORT_EN defined, the module SHALL add ports abort (input, 1) and aborted (output, 1).
REQ-033 With the macro defined, abort=1 sampled in RUN SHALL force DONE at the next edge, with aborted=1 during that DONE cycle; job_cnt still increments.
REQ-034 With the macro defined, abort SHALL be ignored in IDLE and DONE, and aborted SHALL be 0 in all other cycles and under reset.
REQ-035 Without MODE_SEQ_ABORT_EN, the abort and aborted ports SHALL be absent and behaviour SHALL match REQ-014..REQ-027 unchanged.

Verification
REQ-036 Reset release, then req_valid=1 and req_len=3 at edge 1 -> mode=start at cycles 2-4, done_pulse at 5, req_ready=1 at 6, job_cnt=1.
REQ-037 req_len=0 accepted -> no start cycle, done_pulse the next cycle, job_cnt increments.
REQ-038 req_valid held high during RUN with req_len=5 then 2 -> only the first job runs (5 start cycles); the second is accepted only when req_ready returns.
REQ-039 rst pulsed at the 2nd cycle of a req_len=4 job -> mode=done immediately, no done_pulse, job_cnt unchanged.
REQ-040 req_len=255 with LEN_W=8 -> exactly 255 start cycles; also force job_cnt=0xFFFF, then one job -> job_cnt=0x0000.
REQ-041 MODE_SEQ_ABORT_EN defined, req_len=10, abort=1 at the 3rd RUN cycle -> DONE next cycle with aborted=1 and done_pulse=1.
